lcd_char_buffer: RTL and testbench

Character frame buffer feeding the LCD driver's address/data path: holds the 32 characters (2 lines × 16) shown on the Spartan-3E character LCD and serves them by address to the driver's address control unit. Upstream producers write characters through a valid/ready byte interface with terminal-style cursor handling. A dirty flag tells the driver a refresh is due; the driver acknowledges once per completed frame.

---
 rtl/lcd_char_buffer_pkg.sv | 26 ++
 rtl/lcd_char_buffer_char_ram.sv | 35 +++
 rtl/lcd_char_buffer.sv | 139 +++++++++++++
 tb/tb_lcd_char_buffer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_char_buffer_pkg.sv
// Shared constants for the character LCD frame buffer and its driver.
// Geometry, fill character, control codes and buffer state encoding.
package lcd_pkg;

   localparam int          LINE_LEN = 16;
   localparam int          DEPTH    = 2 * LINE_LEN;
   localparam int          ADDR_W   = 5;
   localparam logic [4:0]  LAST_IDX = 5'd31;

   localparam logic [7:0]  BLANK       = 8'h20;
   localparam logic [7:0]  CH_BS       = 8'h08;
   localparam logic [7:0]  CH_LF       = 8'h0A;
   localparam logic [7:0]  CH_CR       = 8'h0D;
   localparam logic [7:0]  CH_PRINT_LO = 8'h20;
   localparam logic [7:0]  CH_PRINT_HI = 8'h7E;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } buf_state_e;

   function automatic logic is_printable(input logic [7:0] c);
      return (c >= CH_PRINT_LO) && (c <= CH_PRINT_HI);
   endfunction

endpackage

// File: rtl/lcd_char_buffer_char_ram.sv
// DEPTH x 8 character store: one write port, registered read port.
// Read-during-write to the same cell returns the previous contents.
module char_ram
   import lcd_pkg::*;
(
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [7:0]        wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [7:0]        rdata_o
);

   logic [7:0] mem_q [DEPTH];
   logic [7:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Only the output register is reset; the array itself is left uninitialised.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         rdata_q <= 8'h00;
      end else begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/lcd_char_buffer.sv
// 2x16 character frame buffer: terminal-style byte writes from producers,
// addressed reads for the LCD driver, self-clearing, and a refresh-due flag.
module lcd_char_buffer
   import lcd_pkg::*;
(
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              wr_valid_i,
   input  logic [7:0]        wr_data_i,
   output logic              wr_ready_o,
   input  logic              cmd_clear_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [7:0]        rd_data_o,
   input  logic              refresh_ack_i,
   output logic              dirty_o,
   output logic [ADDR_W-1:0] cursor_o
);

   buf_state_e        state_q,   state_d;
   logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
   logic [ADDR_W-1:0] cursor_q,  cursor_d;
   logic              dirty_q,   dirty_d;

   logic              we_s;
   logic [ADDR_W-1:0] waddr_s;
   logic [7:0]        wdata_s;
   logic              changed_s;
   logic              wr_ready_s;

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q   <= ST_CLEAR;
         clr_idx_q <= 5'd0;
         cursor_q  <= 5'd0;
         dirty_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         cursor_q  <= cursor_d;
         dirty_q   <= dirty_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      clr_idx_d  = clr_idx_q;
      cursor_d   = cursor_q;
      we_s       = 1'b0;
      waddr_s    = cursor_q;
      wdata_s    = BLANK;
      changed_s  = 1'b0;
      wr_ready_s = 1'b0;

      case (state_q)
         ST_CLEAR: begin
            we_s    = 1'b1;
            waddr_s = clr_idx_q;
            if (clr_idx_q == LAST_IDX) begin
               state_d   = ST_IDLE;
               clr_idx_d = 5'd0;
               cursor_d  = 5'd0;
               changed_s = 1'b1;
            end else begin
               clr_idx_d = clr_idx_q + 5'd1;
            end
         end
         ST_IDLE: begin
            // A clear request blocks the producer for this cycle.
            wr_ready_s = !cmd_clear_i;
            if (cmd_clear_i) begin
               state_d   = ST_CLEAR;
               clr_idx_d = 5'd0;
            end else if (wr_valid_i) begin
               if (is_printable(wr_data_i)) begin
                  we_s      = 1'b1;
                  waddr_s   = cursor_q;
                  wdata_s   = wr_data_i;
                  cursor_d  = cursor_q + 5'd1;
                  changed_s = 1'b1;
               end else begin
                  case (wr_data_i)
                     CH_BS: begin
                        if (cursor_q != 5'd0) begin
                           we_s      = 1'b1;
                           waddr_s   = cursor_q - 5'd1;
                           cursor_d  = cursor_q - 5'd1;
                           changed_s = 1'b1;
                        end else begin
                           changed_s = 1'b0;
                        end
                     end
                     CH_CR: begin
                        cursor_d  = {cursor_q[4], 4'h0};
                        changed_s = (cursor_q[3:0] != 4'h0);
                     end
                     CH_LF: begin
                        cursor_d  = cursor_q + 5'd16;
                        changed_s = 1'b1;
                     end
                     default: begin
                        changed_s = 1'b0;
                     end
                  endcase
               end
            end else begin
               changed_s = 1'b0;
            end
         end
         default: begin
            state_d   = ST_CLEAR;
            clr_idx_d = 5'd0;
         end
      endcase

      // A change in the same cycle as the ack wins, so no update is lost.
      if (changed_s) begin
         dirty_d = 1'b1;
      end else if (refresh_ack_i) begin
         dirty_d = 1'b0;
      end else begin
         dirty_d = dirty_q;
      end
   end

   char_ram u_char_ram (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .we_i     (we_s && reset_ni),
      .waddr_i  (waddr_s),
      .wdata_i  (wdata_s),
      .raddr_i  (rd_addr_i),
      .rdata_o  (rd_data_o)
   );

   assign wr_ready_o = wr_ready_s;
   assign dirty_o    = dirty_q;
   assign cursor_o   = cursor_q;

endmodule

// File: tb/tb_lcd_char_buffer.sv
// Scoreboard bench for lcd_char_buffer: a reference model predicts each cycle,
// a monitor compares DUT outputs against the queued predictions.
module tb_lcd_char_buffer;

   logic       clk_i = 1'b0;
   logic       reset_ni;
   logic       wr_valid_i;
   logic [7:0] wr_data_i;
   logic       wr_ready_o;
   logic       cmd_clear_i;
   logic [4:0] rd_addr_i;
   logic [7:0] rd_data_o;
   logic       refresh_ack_i;
   logic       dirty_o;
   logic [4:0] cursor_o;

   always #5 clk_i = ~clk_i;

   lcd_char_buffer dut (
      .clk_i         (clk_i),
      .reset_ni      (reset_ni),
      .wr_valid_i    (wr_valid_i),
      .wr_data_i     (wr_data_i),
      .wr_ready_o    (wr_ready_o),
      .cmd_clear_i   (cmd_clear_i),
      .rd_addr_i     (rd_addr_i),
      .rd_data_o     (rd_data_o),
      .refresh_ack_i (refresh_ack_i),
      .dirty_o       (dirty_o),
      .cursor_o      (cursor_o)
   );

   typedef struct {
      bit         rdy_known;
      logic       exp_rdy;
      bit         st_known;
      logic [4:0] exp_cur;
      logic       exp_dirty;
      bit         rd_known;
      logic [7:0] exp_rd;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: a 32-byte screen, a cursor and a refresh-due flag.
   byte unsigned m_mem[32];
   bit           m_cell_known[32];
   bit           m_known    = 1'b0;
   bit           m_clearing = 1'b0;
   int           m_clr_cnt  = 0;
   int           m_cur      = 0;
   bit           m_dirty    = 1'b0;
   bit           m_accepted = 1'b0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input bit rst_n, input bit valid, input logic [7:0] data,
                        input bit clr, input bit ack, input logic [4:0] addr);
      exp_t e;
      bit   changed;
      int   nc;
      @(negedge clk_i);
      reset_ni      = rst_n;
      wr_valid_i    = valid;
      wr_data_i     = data;
      cmd_clear_i   = clr;
      refresh_ack_i = ack;
      rd_addr_i     = addr;

      e.rdy_known = m_known;
      e.exp_rdy   = m_known && !m_clearing && !clr;
      e.rd_known  = 1'b0;
      e.exp_rd    = 8'h00;
      m_accepted  = 1'b0;
      changed     = 1'b0;

      if (!rst_n) begin
         e.rd_known = 1'b1;
         m_known    = 1'b1;
         m_clearing = 1'b1;
         m_clr_cnt  = 0;
         m_cur      = 0;
         m_dirty    = 1'b0;
      end else if (m_known) begin
         e.rd_known = m_cell_known[addr];
         e.exp_rd   = m_mem[addr];
         if (m_clearing) begin
            m_mem[m_clr_cnt]        = 8'h20;
            m_cell_known[m_clr_cnt] = 1'b1;
            m_clr_cnt++;
            if (m_clr_cnt == 32) begin
               m_clearing = 1'b0;
               m_cur      = 0;
               changed    = 1'b1;
            end
         end else if (clr) begin
            m_clearing = 1'b1;
            m_clr_cnt  = 0;
         end else if (valid) begin
            m_accepted = 1'b1;
            if (data >= 8'h20 && data <= 8'h7E) begin
               m_mem[m_cur]        = data;
               m_cell_known[m_cur] = 1'b1;
               m_cur               = (m_cur + 1) % 32;
               changed             = 1'b1;
            end else if (data == 8'h08) begin
               if (m_cur > 0) begin
                  m_cur        = m_cur - 1;
                  m_mem[m_cur] = 8'h20;
                  changed      = 1'b1;
               end
            end else if (data == 8'h0D) begin
               nc      = (m_cur / 16) * 16;
               changed = (nc != m_cur);
               m_cur   = nc;
            end else if (data == 8'h0A) begin
               m_cur   = (m_cur + 16) % 32;
               changed = 1'b1;
            end
         end
         if (changed)  m_dirty = 1'b1;
         else if (ack) m_dirty = 1'b0;
      end

      e.st_known  = m_known;
      e.exp_cur   = 5'(m_cur);
      e.exp_dirty = m_dirty;
      sb_q.push_back(e);
   endtask

   task automatic idle(input logic [4:0] addr);
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, addr);
   endtask

   task automatic put(input logic [7:0] c);
      cycle(1'b1, 1'b1, c, 1'b0, 1'b0, 5'($urandom_range(0, 31)));
   endtask

   task automatic wait_clear();
      for (int i = 0; i < 40 && m_clearing; i++) idle(5'($urandom_range(0, 31)));
   endtask

   task automatic do_clear();
      cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0);
      wait_clear();
   endtask

   function automatic logic [7:0] rand_char();
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5)      return 8'($urandom_range(32, 126));
      else if (r == 6) return 8'h08;
      else if (r == 7) return 8'h0D;
      else if (r == 8) return 8'h0A;
      else             return 8'($urandom_range(0, 255));
   endfunction

   // Monitor: wr_ready sampled before the edge, registered outputs after it.
   initial begin
      logic r;
      exp_t e;
      forever begin
         @(negedge clk_i);
         #2;
         r = wr_ready_o;
         @(posedge clk_i);
         #1;
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            if (e.rdy_known) chk("wr_ready", {7'd0, r}, {7'd0, e.exp_rdy});
            if (e.st_known) begin
               chk("cursor", {3'd0, cursor_o}, {3'd0, e.exp_cur});
               chk("dirty", {7'd0, dirty_o}, {7'd0, e.exp_dirty});
            end
            if (e.rd_known) chk("rd_data", rd_data_o, e.exp_rd);
         end
      end
   end

   initial begin
      reset_ni      = 1'b0;
      wr_valid_i    = 1'b0;
      wr_data_i     = 8'h00;
      cmd_clear_i   = 1'b0;
      refresh_ack_i = 1'b0;
      rd_addr_i     = 5'd0;

      // Reset, full clear, then every cell reads back blank.
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
      for (int i = 0; i < 33; i++) idle(5'(i));
      for (int i = 0; i < 32; i++) idle(5'(i));
      idle(5'd0);

      // "HI" back to back, then refresh acknowledge.
      put(8'h48);
      put(8'h49);
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0);
      idle(5'd1);
      idle(5'd2);

      // Last column of line 0, line feed, then a full-screen wrap.
      do_clear();
      for (int i = 0; i < 15; i++) put(8'($urandom_range(32, 126)));
      put(8'h41);
      put(8'h0A);
      idle(5'd15);
      for (int i = 0; i < 32; i++) put(8'($urandom_range(32, 126)));
      idle(5'd0);
      idle(5'd31);

      // Backspace, backspace at home, carriage return.
      do_clear();
      for (int i = 0; i < 5; i++) put(8'($urandom_range(32, 126)));
      put(8'h08);
      idle(5'd4);
      put(8'h0D);
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0);
      put(8'h08);
      for (int i = 0; i < 4; i++) put(8'($urandom_range(32, 126)));
      put(8'h0A);
      put(8'h0D);
      put(8'h0D);

      // Clear wins over a simultaneous byte; the held byte lands in cell 0.
      cycle(1'b1, 1'b1, 8'h51, 1'b1, 1'b0, 5'd0);
      for (int i = 0; i < 40; i++) begin
         cycle(1'b1, 1'b1, 8'h51, 1'b0, 1'b0, 5'd0);
         if (m_accepted) break;
      end
      idle(5'd0);
      idle(5'd0);

      // Reset at clear index 10, full clear again, then ack alongside a write.
      cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0);
      for (int i = 0; i < 10; i++) idle(5'(i));
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd3);
      for (int i = 0; i < 33; i++) idle(5'(i));
      cycle(1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 5'd0);
      idle(5'd0);

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 499) != 0),
               ($urandom_range(0, 1) == 1),
               rand_char(),
               ($urandom_range(0, 39) == 0),
               ($urandom_range(0, 7) == 0),
               5'($urandom_range(0, 31)));
      end
      idle(5'd0);

      repeat (3) @(posedge clk_i);
      #3;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
